hash_mon_sched: RTL and testbench

Round-robin scheduler that shares one instruction-hash checker among `NUM_CORES` soft cores in the multicore security monitor. Each core offers a fetched instruction word and its word address; the scheduler grants one core at a time, computes the 4-bit hash, fetches the expected hash from the shared reference-hash RAM, and raises a per-core sticky mismatch interrupt. It sits between the per-core fetch taps and the reference-hash memory, replacing one hash unit per core.

---
 rtl/hash_mon_pkg.sv | 34 +++
 rtl/hash_mon_sched_rr_arbiter.sv | 63 ++++++
 rtl/hash_mon_sched.sv | 213 +++++++++++++++++++++
 tb/tb_hash_mon_sched.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_mon_pkg.sv
// ---------------------------------------------------------------------------
// hash_mon_pkg
// Shared types and constants for the instruction-hash monitor scheduler.
//   state_e   : scheduler FSM states
//   INST_W    : instruction word width
//   HASH_W    : hash width
//   CNT_W     : mismatch counter width
//   ID_W      : core id field width in the reference-RAM address
//   hash4()   : popcount of an instruction word, modulo 16
// ---------------------------------------------------------------------------
package hash_mon_pkg;

    localparam int INST_W = 32;
    localparam int HASH_W = 4;
    localparam int CNT_W  = 16;
    localparam int ID_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    // 6-bit popcount; only the low 4 bits form the hash.
    function automatic logic [HASH_W-1:0] hash4(input logic [INST_W-1:0] word);
        logic [5:0] sum;
        sum = '0;
        for (int i = 0; i < INST_W; i++) begin
            sum = sum + {5'd0, word[i]};
        end
        return sum[HASH_W-1:0];
    endfunction

endpackage

// File: rtl/hash_mon_sched_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Rotating-priority arbiter. The request at the pointer position has the
// highest priority; after an accepted grant to index k the pointer moves to
// k+1 (wrapping to 0).
//   clk       : clock
//   rst       : asynchronous active-high reset, pointer -> 0
//   req       : request vector
//   advance   : the current grant was taken, rotate the pointer
//   grant     : one-hot grant (combinational from req and pointer)
//   grant_any : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant,
    output logic         grant_any
);

    localparam int PTR_W = $clog2(N);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic             blocked;

    // Distance of an index from the pointer; smaller means higher priority.
    function automatic int rank(input int idx, input int p);
        return (idx >= p) ? (idx - p) : (idx - p + N);
    endfunction

    always_comb begin
        grant   = '0;
        ptr_d   = ptr_q;
        blocked = 1'b0;
        for (int i = 0; i < N; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < N; j++) begin
                if (req[j] && (rank(j, int'(ptr_q)) < rank(i, int'(ptr_q)))) begin
                    blocked = 1'b1;
                end
            end
            if (req[i] && !blocked) begin
                grant[i] = 1'b1;
                ptr_d    = (i == N - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    assign grant_any = |req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (advance && grant_any) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/hash_mon_sched.sv
// ---------------------------------------------------------------------------
// hash_mon_sched
// Shares one instruction-hash checker among NUM_CORES cores. One core is
// granted at a time (round robin), its 4-bit hash is compared with the value
// read from the reference-hash RAM and a sticky per-core interrupt is raised
// on mismatch.
//
// Optional feature macro: HASH_MON_DEDUP_EN
//   When defined, a request repeating that core's last checked address is
//   accepted without a RAM read or compare (FSM stays in IDLE).
//
// Ports
//   core_sp_clk   : clock, rising edge
//   reset         : asynchronous active-high reset
//   mon_en        : per-core monitoring enable (masks requests)
//   inst_valid    : per-core instruction offer
//   inst_data     : instruction words, core i at [32i+31:32i]
//   inst_addr     : word addresses, core i at [ADDR_W*i +: ADDR_W]
//   inst_ready    : one-hot accept pulse (registered)
//   ref_rd_en     : reference-RAM read strobe (registered)
//   ref_rd_addr   : {core id (3 b), word address}
//   ref_rd_data   : expected hash, valid one cycle after ref_rd_en
//   irq_ack       : clears matching mismatch_irq bit
//   mismatch_irq  : sticky per-core mismatch flags
//   mismatch_cnt  : saturating total mismatch count
//   busy          : FSM not in IDLE
//
// FSM
//   state    | meaning
//   ST_IDLE  | waiting for an eligible request; grant + RAM read on entry
//   ST_FETCH | RAM read in flight
//   ST_CHECK | RAM data valid; compare against latched hash
// ---------------------------------------------------------------------------
module hash_mon_sched
    import hash_mon_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 12
) (
    input  logic                        core_sp_clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        mon_en,
    input  logic [NUM_CORES-1:0]        inst_valid,
    input  logic [NUM_CORES*INST_W-1:0] inst_data,
    input  logic [NUM_CORES*ADDR_W-1:0] inst_addr,
    output logic [NUM_CORES-1:0]        inst_ready,
    output logic                        ref_rd_en,
    output logic [ADDR_W+ID_W-1:0]      ref_rd_addr,
    input  logic [HASH_W-1:0]           ref_rd_data,
    input  logic [NUM_CORES-1:0]        irq_ack,
    output logic [NUM_CORES-1:0]        mismatch_irq,
    output logic [CNT_W-1:0]            mismatch_cnt,
    output logic                        busy
);

    state_e                   state_q;
    logic [NUM_CORES-1:0]     ready_q;
    logic                     rd_en_q;
    logic [ADDR_W+ID_W-1:0]   rd_addr_q;
    logic [HASH_W-1:0]        hash_q;
    logic [ID_W-1:0]          id_q;
    logic                     pend_q;
    logic [ID_W-1:0]          pend_id_q;
    logic [NUM_CORES-1:0]     irq_q;
    logic [NUM_CORES-1:0]     irq_d;
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         cnt_d;

    logic [NUM_CORES-1:0]     req;
    logic [NUM_CORES-1:0]     grant;
    logic                     grant_any;
    logic                     grant_take;
    logic [INST_W-1:0]        sel_data;
    logic [ADDR_W-1:0]        sel_addr;
    logic [ID_W-1:0]          sel_id;
    logic                     dup_hit;

    // A core whose accept pulse is on the wire this cycle may still show its
    // old word; masking it prevents a double accept of the same instruction.
    assign req        = inst_valid & mon_en & ~ready_q;
    assign grant_take = (state_q == ST_IDLE) && grant_any;

    rr_arbiter #(
        .N (NUM_CORES)
    ) u_arb (
        .clk       (core_sp_clk),
        .rst       (reset),
        .req       (req),
        .advance   (grant_take),
        .grant     (grant),
        .grant_any (grant_any)
    );

    always_comb begin
        sel_data = '0;
        sel_addr = '0;
        sel_id   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant[i]) begin
                sel_data = inst_data[i*INST_W +: INST_W];
                sel_addr = inst_addr[i*ADDR_W +: ADDR_W];
                sel_id   = ID_W'(i);
            end
        end
    end

`ifdef HASH_MON_DEDUP_EN
    logic [ADDR_W-1:0] last_addr_q [NUM_CORES];

    always_comb begin
        dup_hit = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant[i] && (last_addr_q[i] == sel_addr)) begin
                dup_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge core_sp_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                last_addr_q[i] <= '1;
            end
        end else if (grant_take && !dup_hit) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (grant[i]) begin
                    last_addr_q[i] <= sel_addr;
                end
            end
        end
    end
`else
    assign dup_hit = 1'b0;
`endif

    // Compare result is registered into pend_q and applied to the flags one
    // cycle later, giving grant-to-flag latency of three cycles.
    always_ff @(posedge core_sp_clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ready_q   <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            hash_q    <= '0;
            id_q      <= '0;
            pend_q    <= 1'b0;
            pend_id_q <= '0;
        end else begin
            ready_q <= '0;
            rd_en_q <= 1'b0;
            pend_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_any) begin
                        ready_q <= grant;
                        if (!dup_hit) begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= {sel_id, sel_addr};
                            hash_q    <= hash4(sel_data);
                            id_q      <= sel_id;
                            state_q   <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    pend_q    <= (ref_rd_data != hash_q);
                    pend_id_q <= id_q;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // A new mismatch wins over a coincident acknowledge.
    always_comb begin
        irq_d = irq_q & ~irq_ack;
        cnt_d = cnt_q;
        if (pend_q) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (pend_id_q == ID_W'(i)) begin
                    irq_d[i] = 1'b1;
                end
            end
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge core_sp_clk or posedge reset) begin
        if (reset) begin
            irq_q <= '0;
            cnt_q <= '0;
        end else begin
            irq_q <= irq_d;
            cnt_q <= cnt_d;
        end
    end

    assign inst_ready   = ready_q;
    assign ref_rd_en    = rd_en_q;
    assign ref_rd_addr  = rd_addr_q;
    assign mismatch_irq = irq_q;
    assign mismatch_cnt = cnt_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hash_mon_sched.sv
`timescale 1ns/1ps
module tb_hash_mon_sched;

    localparam int NC = 4;
    localparam int AW = 12;

    logic            clk = 1'b0;
    logic            rst;
    logic [NC-1:0]   mon_en;
    logic [NC-1:0]   inst_valid;
    logic [NC*32-1:0] inst_data;
    logic [NC*AW-1:0] inst_addr;
    logic [NC-1:0]   inst_ready;
    logic            ref_rd_en;
    logic [AW+2:0]   ref_rd_addr;
    logic [3:0]      ref_rd_data;
    logic [NC-1:0]   irq_ack;
    logic [NC-1:0]   mismatch_irq;
    logic [15:0]     mismatch_cnt;
    logic            busy;

    hash_mon_sched #(.NUM_CORES(NC), .ADDR_W(AW)) dut (
        .core_sp_clk  (clk),
        .reset        (rst),
        .mon_en       (mon_en),
        .inst_valid   (inst_valid),
        .inst_data    (inst_data),
        .inst_addr    (inst_addr),
        .inst_ready   (inst_ready),
        .ref_rd_en    (ref_rd_en),
        .ref_rd_addr  (ref_rd_addr),
        .ref_rd_data  (ref_rd_data),
        .irq_ack      (irq_ack),
        .mismatch_irq (mismatch_irq),
        .mismatch_cnt (mismatch_cnt),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Reference RAM: per-core return value, valid only the cycle after the
    // read strobe; inverted afterwards so late sampling shows up.
    logic [3:0] ram_ret [8];
    always @(posedge clk or posedge rst) begin
        if (rst)
            ref_rd_data <= 4'h0;
        else if (ref_rd_en)
            ref_rd_data <= ram_ret[ref_rd_addr[AW+2:AW]];
        else
            ref_rd_data <= ~ref_rd_data;
    end

    typedef struct {
        int          core;
        logic [31:0] data;
        logic [AW-1:0] addr;
        logic [3:0]  hash;
        logic [3:0]  ram;
    } vec_t;

    typedef struct {
        int          core;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;
    logic [NC-1:0] irq_exp;
    logic [15:0]   cnt_exp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input int c, input logic [31:0] d, input logic [AW-1:0] a);
        inst_valid[c] = 1'b1;
        inst_data[c*32 +: 32] = d;
        inst_addr[c*AW +: AW] = a;
    endtask

    task automatic wait_ready(input int limit, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (inst_ready != '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: no inst_ready within %0d cycles", limit);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        inst_valid = '0;
        irq_ack = '0;
        @(negedge clk);
        rst = 1'b0;
        irq_exp = '0;
        cnt_exp = '0;
        sbq.delete();
    endtask

    task automatic run_one(input vec_t v, input bit coincide);
        exp_t e;
        logic ok;
        logic [NC-1:0] irq_prev;
        bit mis;
        ram_ret[v.core] = v.ram;
        @(negedge clk);
        drive_req(v.core, v.data, v.addr);
        sbq.push_back('{core: v.core, addr: v.addr});
        wait_ready(8, ok);
        if (!ok) begin
            inst_valid = '0;
            sbq.delete();
            return;
        end
        e = sbq.pop_front();
        chk("grant_onehot", 32'(inst_ready), 32'd1 << e.core);
        chk("rd_en", 32'(ref_rd_en), 32'd1);
        chk("rd_addr", 32'(ref_rd_addr), 32'({3'(e.core), e.addr}));
        chk("busy_fetch", 32'(busy), 32'd1);
        inst_valid = '0;
        irq_prev = irq_exp;
        mis = (v.hash != v.ram);
        if (mis) begin
            irq_exp[v.core] = 1'b1;
            if (cnt_exp != 16'hFFFF) cnt_exp = cnt_exp + 16'd1;
        end
        @(negedge clk);
        chk("ready_pulse_len", 32'(inst_ready), 32'd0);
        @(negedge clk);
        chk("irq_not_early", 32'(mismatch_irq), 32'(irq_prev));
        if (coincide) irq_ack[v.core] = 1'b1;
        @(negedge clk);
        irq_ack = '0;
        chk("irq_at_grant3", 32'(mismatch_irq), 32'(irq_exp));
        chk("cnt", 32'(mismatch_cnt), 32'(cnt_exp));
    endtask

    task automatic ack_core(input int c);
        @(negedge clk);
        irq_ack[c] = 1'b1;
        @(negedge clk);
        irq_ack = '0;
        irq_exp[c] = 1'b0;
        chk("irq_ack_clear", 32'(mismatch_irq), 32'(irq_exp));
    endtask

    task automatic rr_run(input logic [NC-1:0] en, input int seq[$]);
        exp_t e;
        int last_cyc;
        int cyc;
        do_reset();
        mon_en = en;
        for (int c = 0; c < NC; c++) begin
            ram_ret[c] = 4'h0;
            drive_req(c, 32'h0, AW'(12'h400 + c * 16));
        end
        foreach (seq[k]) sbq.push_back('{core: seq[k], addr: '0});
        last_cyc = -1;
        cyc = 0;
        while (sbq.size() != 0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (inst_ready != '0) begin
                e = sbq.pop_front();
                chk("rr_order", 32'(inst_ready), 32'd1 << e.core);
                if (last_cyc >= 0) chk("rr_spacing", 32'(cyc - last_cyc), 32'd3);
                last_cyc = cyc;
                for (int c = 0; c < NC; c++)
                    if (inst_ready[c]) inst_addr[c*AW +: AW] = inst_addr[c*AW +: AW] + AW'(1);
            end
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL rr_timeout: %0d grants missing", sbq.size());
            sbq.delete();
        end
        inst_valid = '0;
        mon_en = '1;
        repeat (4) @(negedge clk);
    endtask

    vec_t vt[6];
    vec_t hv;
    exp_t he;
    logic hok;
    int seen;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{core: 0, data: 32'h0000_000F, addr: 12'h100, hash: 4'h4, ram: 4'h4};
        vt[1] = '{core: 2, data: 32'hFFFF_FFFF, addr: 12'h204, hash: 4'h0, ram: 4'h1};
        vt[2] = '{core: 1, data: 32'h1234_5678, addr: 12'h0A0, hash: 4'hD, ram: 4'hD};
        vt[3] = '{core: 3, data: 32'h8000_0001, addr: 12'h3FF, hash: 4'h2, ram: 4'h3};
        vt[4] = '{core: 0, data: 32'hFFFF_0000, addr: 12'h101, hash: 4'h0, ram: 4'h0};
        vt[5] = '{core: 1, data: 32'h7FFF_FFFF, addr: 12'h0A1, hash: 4'hF, ram: 4'hE};

        for (int i = 0; i < 8; i++) ram_ret[i] = 4'h0;
        rst = 1'b1;
        mon_en = '1;
        inst_valid = '0;
        inst_data = '0;
        inst_addr = '0;
        irq_ack = '0;
        irq_exp = '0;
        cnt_exp = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(inst_ready), 32'd0);
        chk("rst_rd_en", 32'(ref_rd_en), 32'd0);
        chk("rst_rd_addr", 32'(ref_rd_addr), 32'd0);
        chk("rst_irq", 32'(mismatch_irq), 32'd0);
        chk("rst_cnt", 32'(mismatch_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Table-driven single requests
        for (int v = 0; v < 6; v++) begin
            run_one(vt[v], 1'b0);
            if (vt[v].hash != vt[v].ram) begin
                @(negedge clk);
                irq_ack[(vt[v].core + 1) % NC] = 1'b1;
                @(negedge clk);
                irq_ack = '0;
                chk("ack_clear_bit_noop", 32'(mismatch_irq), 32'(irq_exp));
                ack_core(vt[v].core);
            end
        end

        // Disabled core is never accepted
        mon_en = 4'b1011;
        @(negedge clk);
        drive_req(2, 32'h1, 12'h222);
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (inst_ready != '0 || busy) seen++;
        end
        chk("masked_core_ignored", 32'(seen), 32'd0);
        inst_valid = '0;
        mon_en = '1;

        // Mismatch coincident with acknowledge on core 3
        hv = '{core: 3, data: 32'h0000_0003, addr: 12'h3F0, hash: 4'h2, ram: 4'h5};
        run_one(hv, 1'b0);
        hv.addr = 12'h3F1;
        run_one(hv, 1'b1);
        ack_core(3);

        // Counter saturation
        @(negedge clk);
        force dut.cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.cnt_q;
        #1;
        cnt_exp = 16'hFFFE;
        chk("cnt_preload", 32'(mismatch_cnt), 32'(cnt_exp));
        hv = '{core: 0, data: 32'h0000_0001, addr: 12'h120, hash: 4'h1, ram: 4'h7};
        run_one(hv, 1'b0);
        hv.addr = 12'h121;
        run_one(hv, 1'b0);
        ack_core(0);

`ifndef HASH_MON_DEDUP_EN
        // Repeated address is fully checked when dedup is not built in
        hv = '{core: 2, data: 32'h0000_00FF, addr: 12'h250, hash: 4'h8, ram: 4'h8};
        run_one(hv, 1'b0);
        hv.ram = 4'h9;
        run_one(hv, 1'b0);
        ack_core(2);
`endif

        // Reset asserted during FETCH
        ram_ret[1] = 4'hF;
        @(negedge clk);
        drive_req(1, 32'h0000_0000, 12'h0B0);
        wait_ready(8, hok);
        if (hok) begin
            rst = 1'b1;
            #1;
            chk("midrst_ready", 32'(inst_ready), 32'd0);
            chk("midrst_rd_en", 32'(ref_rd_en), 32'd0);
            chk("midrst_rd_addr", 32'(ref_rd_addr), 32'd0);
            chk("midrst_cnt", 32'(mismatch_cnt), 32'd0);
            chk("midrst_busy", 32'(busy), 32'd0);
        end
        inst_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        irq_exp = '0;
        cnt_exp = '0;
        repeat (5) @(negedge clk);
        chk("postrst_irq", 32'(mismatch_irq), 32'd0);
        chk("postrst_cnt", 32'(mismatch_cnt), 32'd0);

        // Round-robin order with continuous requests
        rr_run(4'hF, '{0, 1, 2, 3, 0});
        rr_run(4'hD, '{0, 2, 3, 0});

`ifdef HASH_MON_DEDUP_EN
        // Repeated address on core 1 is accepted without a check
        do_reset();
        hv = '{core: 1, data: 32'h0000_0007, addr: 12'h010, hash: 4'h3, ram: 4'h3};
        run_one(hv, 1'b0);
        ram_ret[1] = 4'hC;
        @(negedge clk);
        drive_req(1, 32'h0000_0007, 12'h010);
        sbq.push_back('{core: 1, addr: 12'h010});
        wait_ready(8, hok);
        if (hok) begin
            he = sbq.pop_front();
            chk("dedup_ready", 32'(inst_ready), 32'd1 << he.core);
            chk("dedup_no_rd", 32'(ref_rd_en), 32'd0);
            chk("dedup_not_busy", 32'(busy), 32'd0);
        end
        inst_valid = '0;
        sbq.delete();
        repeat (4) @(negedge clk);
        chk("dedup_irq", 32'(mismatch_irq), 32'd0);
        chk("dedup_cnt", 32'(mismatch_cnt), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
